demux1to4_stream: RTL

- Registered 1-to-NOUT stream demultiplexer with valid/ready handshake; the distribution-side counterpart of the 4-to-1 bit-select muxes.
- Routes whole packets from one input stream to one of NOUT output channels; destination latched on the first beat, held until the last beat.
- Sits between a single producer (e.g. ALU result stream) and NOUT consumers.

---
 rtl/demux_pkg.sv | 19 +
 rtl/demux_hold_reg.sv | 70 +++++++
 rtl/demux1to4_stream.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the packet stream demultiplexer.
package demux_pkg;

  // Routing FSM states (encoding fixed so the state can be probed in debug).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  // Width of every statistics counter.
  localparam int STAT_W = 16;

  // Select width for n channels, never below one bit.
  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_hold_reg.sv
// Single-entry valid/ready holding register with a destination field.
// The held beat drains when the ready of its own destination is high;
// a new beat may load in the same cycle, keeping one beat per cycle.
module demux_hold_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NOUT  = 4,
  parameter int SELW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  input  logic             i_dest_we,
  input  logic [SELW-1:0]  i_dest,
  input  logic [NOUT-1:0]  i_out_ready,
  output logic             o_hold_valid,
  output logic             o_space,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic [NOUT-1:0]  o_valid,
  output logic [SELW-1:0]  o_dest
);

  logic             r_hold_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_last;
  logic [SELW-1:0]  r_dest;
  logic             w_dst_ready;
  logic             w_drain;

  // Only the ready of the current destination matters; the others are ignored.
  assign w_dst_ready = i_out_ready[r_dest];
  assign w_drain     = r_hold_valid & w_dst_ready;
  assign o_space     = !r_hold_valid | w_dst_ready;

  // Beat storage: load wins over drain so accept+drain sustains full rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_data       <= '0;
      r_last       <= 1'b0;
    end else if (i_load) begin
      r_hold_valid <= 1'b1;
      r_data       <= i_data;
      r_last       <= i_last;
    end else if (w_drain) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Destination only moves when a new packet is opened.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_dest <= '0;
    else if (i_dest_we) r_dest <= i_dest;
  end

  // One-hot valid decode of the held beat's destination.
  for (genvar g = 0; g < NOUT; g++) begin : g_vld
    assign o_valid[g] = r_hold_valid & (r_dest == SELW'(g));
  end

  assign o_hold_valid = r_hold_valid;
  assign o_data       = r_data;
  assign o_last       = r_last;
  assign o_dest       = r_dest;

endmodule

// File: rtl/demux1to4_stream.sv
// Registered 1-to-NOUT packet stream demultiplexer (valid/ready).
// The destination is taken from in_sel on the first beat of a packet and
// held until the last beat; packets with an out-of-range select are
// swallowed and flagged on err_sel.
// Optional per-channel beat and drop counters: define DEMUX_STATS_EN.
module demux1to4_stream
  import demux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NOUT  = 4,
  localparam int SELW  = sel_w(NOUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SELW-1:0]  in_sel,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [NOUT-1:0]  out_valid,
  input  logic [NOUT-1:0]  out_ready,
  output logic             busy,
  output logic             err_sel
`ifdef DEMUX_STATS_EN
  ,
  output logic [NOUT*STAT_W-1:0] beat_cnt,
  output logic [STAT_W-1:0]      drop_cnt
`endif
);

  localparam logic [SELW:0] NOUT_L = (SELW+1)'(NOUT);

  state_t          r_state, w_state_nxt;
  logic            r_err_sel;
  logic            w_accept;
  logic            w_sel_ok;
  logic            w_load;
  logic            w_dest_we;
  logic            w_err;
  logic            w_space;
  logic            w_hold_valid;
  logic [SELW-1:0] w_dest;

  assign w_sel_ok = {1'b0, in_sel} < NOUT_L;
  // DROP swallows beats unconditionally, so it never waits on a consumer.
  assign in_ready = (r_state == DROP) | w_space;
  assign w_accept = in_valid & in_ready;

  // Routing FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and datapath controls for each accepted beat.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dest_we   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_sel_ok) begin
            w_load      = 1'b1;
            w_dest_we   = 1'b1;
            w_state_nxt = in_last ? IDLE : FWD;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = in_last ? IDLE : DROP;
          end
        end
      end
      FWD: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (in_last) w_state_nxt = IDLE;
        end
      end
      DROP: begin
        if (w_accept && in_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bad-select flag, one cycle after the offending first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err_sel <= 1'b0;
    else        r_err_sel <= w_err;
  end

  demux_hold_reg #(
    .WIDTH (WIDTH),
    .NOUT  (NOUT),
    .SELW  (SELW)
  ) u_hold (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load),
    .i_data       (in_data),
    .i_last       (in_last),
    .i_dest_we    (w_dest_we),
    .i_dest       (in_sel),
    .i_out_ready  (out_ready),
    .o_hold_valid (w_hold_valid),
    .o_space      (w_space),
    .o_data       (out_data),
    .o_last       (out_last),
    .o_valid      (out_valid),
    .o_dest       (w_dest)
  );

  assign busy    = (r_state != IDLE) | w_hold_valid;
  assign err_sel = r_err_sel;

`ifdef DEMUX_STATS_EN
  logic              w_drop;
  logic [STAT_W-1:0] r_drop_cnt;

  // A beat is discarded when swallowed in DROP or rejected as a bad first beat.
  assign w_drop = w_accept & ((r_state == DROP) | ((r_state == IDLE) & !w_sel_ok));

  // Per-channel delivered-beat counters, wrapping.
  for (genvar g = 0; g < NOUT; g++) begin : g_stat
    logic [STAT_W-1:0] r_beat_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_beat_cnt <= '0;
      else if (out_valid[g] & out_ready[g]) r_beat_cnt <= r_beat_cnt + 1'b1;
    end
    assign beat_cnt[g*STAT_W +: STAT_W] = r_beat_cnt;
  end

  // Discarded-beat counter, wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_drop_cnt <= '0;
    else if (w_drop) r_drop_cnt <= r_drop_cnt + 1'b1;
  end
  assign drop_cnt = r_drop_cnt;
`else
  logic w_unused;
  assign w_unused = ^w_dest;
`endif

endmodule
